// File: rtl/zx_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : zx_mem_arbiter
// Purpose  : Shares the external video/CPU SRAM bus between video fetch, CPU
//            and DMA. Fixed priority (video > CPU > DMA) with a CPU
//            anti-starvation streak counter. Each access is sequenced as
//            IDLE -> ACCESS -> ACK and completes with a one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module zx_mem_arbiter #(
  parameter int RD_CYCLES      = 2,
  parameter int WR_CYCLES      = 2,
  parameter int CPU_STARVE_MAX = 4
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [18:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_data,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [18:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [18:0] va,
  input  logic [7:0]  vd_i,
  output logic [7:0]  vd_o,
  output logic        vd_oe,
  output logic        n_vrd,
  output logic        n_vwr
);

  // Counter widths: streak needs at least 3 bits, access counter holds N-1
  localparam int c_STREAK_W = ($clog2(CPU_STARVE_MAX + 1) > 3) ? $clog2(CPU_STARVE_MAX + 1) : 3;
  localparam int c_MAX_N    = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int c_CNT_W    = (c_MAX_N > 1) ? $clog2(c_MAX_N) : 1;

  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(CPU_STARVE_MAX);
  localparam logic [c_CNT_W-1:0]    c_RD_LOAD    = c_CNT_W'(RD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]    c_WR_LOAD    = c_CNT_W'(WR_CYCLES - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_ACK    = 2'd2;

  localparam logic [1:0] c_OWN_VID = 2'd0;
  localparam logic [1:0] c_OWN_CPU = 2'd1;
  localparam logic [1:0] c_OWN_DMA = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [1:0]            r_owner;
  logic [18:0]           r_addr;
  logic                  r_wr;
  logic [7:0]            r_wdata;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_STREAK_W-1:0] r_streak;
  logic [7:0]            r_vid_data;
  logic [7:0]            r_cpu_rdata;
  logic [7:0]            r_dma_rdata;

  logic                  w_grant;
  logic                  w_grant_vid;
  logic                  w_grant_cpu;
  logic                  w_force_cpu;
  logic [1:0]            w_sel_owner;
  logic [18:0]           w_sel_addr;
  logic                  w_sel_wr;
  logic [7:0]            w_sel_wdata;

  assign w_force_cpu = cpu_req && (r_streak == c_STREAK_MAX);

  // Arbitration: choose one winner per IDLE cycle and mux its request fields
  always_comb begin
    w_grant     = 1'b0;
    w_grant_vid = 1'b0;
    w_grant_cpu = 1'b0;
    w_sel_owner = c_OWN_VID;
    w_sel_addr  = vid_addr;
    w_sel_wr    = 1'b0;
    w_sel_wdata = 8'h00;
    if (r_state == c_IDLE) begin
      if (w_force_cpu || (!vid_req && cpu_req)) begin
        w_grant     = 1'b1;
        w_grant_cpu = 1'b1;
        w_sel_owner = c_OWN_CPU;
        w_sel_addr  = cpu_addr;
        w_sel_wr    = cpu_wr;
        w_sel_wdata = cpu_wdata;
      end else if (vid_req) begin
        w_grant     = 1'b1;
        w_grant_vid = 1'b1;
      end else if (dma_req) begin
        w_grant     = 1'b1;
        w_sel_owner = c_OWN_DMA;
        w_sel_addr  = dma_addr;
        w_sel_wr    = dma_wr;
        w_sel_wdata = dma_wdata;
      end
    end
  end

  // State register
  always_ff @(posedge clk28) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (w_grant) w_next_state = c_ACCESS;
      c_ACCESS: if (r_cnt == '0) w_next_state = c_ACK;
      c_ACK:    w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  // Datapath: latch the granted request, count access cycles, capture reads, track streak
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      r_owner     <= c_OWN_VID;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_vid_data  <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_sel_owner;
        r_addr  <= w_sel_addr;
        r_wr    <= w_sel_wr;
        r_wdata <= w_sel_wdata;
        r_cnt   <= w_sel_wr ? c_WR_LOAD : c_RD_LOAD;
        // Any CPU grant, or any grant without CPU waiting, ends the streak
        if (w_grant_cpu || !cpu_req)
          r_streak <= '0;
        else if (w_grant_vid && (r_streak != c_STREAK_MAX))
          r_streak <= r_streak + 1'b1;
      end
      if (r_state == c_ACCESS) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else if (!r_wr) begin
          case (r_owner)
            c_OWN_VID: r_vid_data  <= vd_i;
            c_OWN_CPU: r_cpu_rdata <= vd_i;
            default:   r_dma_rdata <= vd_i;
          endcase
        end
      end
    end
  end

  // Bus strobes and acks decoded from state; last write cycle releases n_vwr for data hold
  always_comb begin
    n_vrd   = 1'b1;
    n_vwr   = 1'b1;
    vd_oe   = 1'b0;
    vd_o    = 8'h00;
    vid_ack = 1'b0;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    case (r_state)
      c_ACCESS: begin
        if (r_wr) begin
          vd_oe = 1'b1;
          vd_o  = r_wdata;
          n_vwr = (r_cnt == '0);
        end else begin
          n_vrd = 1'b0;
        end
      end
      c_ACK: begin
        vid_ack = (r_owner == c_OWN_VID);
        cpu_ack = (r_owner == c_OWN_CPU);
        dma_ack = (r_owner == c_OWN_DMA);
      end
      default: ;
    endcase
  end

  assign va        = r_addr;
  assign vid_data  = r_vid_data;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;

endmodule
`default_nettype wire

// File: tb/tb_zx_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_zx_mem_arbiter
// Purpose  : Directed self-checking bench for zx_mem_arbiter with a simple
//            asynchronous-read SRAM model on the va/vd bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zx_mem_arbiter;

  logic        clk28 = 1'b0;
  logic        rst_n;
  logic        vid_req, cpu_req, cpu_wr, dma_req, dma_wr;
  logic [18:0] vid_addr, cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        vid_ack, cpu_ack, dma_ack;
  logic [7:0]  vid_data, cpu_rdata, dma_rdata;
  logic [18:0] va;
  logic [7:0]  vd_i, vd_o;
  logic        vd_oe, n_vrd, n_vwr;

  logic [7:0]  mem [0:524287];

  int checks = 0;
  int errors = 0;

  always #18 clk28 = ~clk28;

  zx_mem_arbiter #(.RD_CYCLES(2), .WR_CYCLES(2), .CPU_STARVE_MAX(4)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .va(va), .vd_i(vd_i), .vd_o(vd_o), .vd_oe(vd_oe), .n_vrd(n_vrd), .n_vwr(n_vwr)
  );

  // SRAM model: asynchronous read, write on clock edge while n_vwr is low
  assign vd_i = mem[va];
  always @(posedge clk28) if (!n_vwr) mem[va] <= vd_o;

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic cpu_xfer(input logic wr, input logic [18:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
    cpu_wr = wr; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    lat = 0; rd = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_ack) begin lat = i; rd = cpu_rdata; break; end
    end
    cpu_req = 1'b0;
  endtask

  task automatic dma_xfer(input logic wr, input logic [18:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
    dma_wr = wr; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    lat = 0; rd = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dma_ack) begin lat = i; rd = dma_rdata; break; end
    end
    dma_req = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({va, vd_o, vd_oe, n_vrd, n_vwr} !== {19'h0, 8'h00, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_bus: got va=%h vd_o=%h oe=%b rd=%b wr=%b, want 0 0 0 1 1",
               va, vd_o, vd_oe, n_vrd, n_vwr);
    end
    checks++;
    if ({vid_ack, cpu_ack, dma_ack, vid_data, cpu_rdata, dma_rdata} !== 27'h0) begin
      errors++;
      $display("FAIL reset_outputs: got acks=%b%b%b data=%h %h %h, want all 0",
               vid_ack, cpu_ack, dma_ack, vid_data, cpu_rdata, dma_rdata);
    end
  endtask

  task automatic test_cpu_read();
    cpu_wr = 1'b0; cpu_addr = 19'h00005; cpu_req = 1'b1;   // cycle T
    tick();                                                // T+1
    checks++;
    if ({n_vrd, n_vwr, vd_oe, va} !== {1'b0, 1'b1, 1'b0, 19'h00005}) begin
      errors++;
      $display("FAIL rd_access1: got rd=%b wr=%b oe=%b va=%h, want 0 1 0 00005", n_vrd, n_vwr, vd_oe, va);
    end
    tick();                                                // T+2
    checks++;
    if ({n_vrd, cpu_ack} !== 2'b00) begin
      errors++;
      $display("FAIL rd_access2: got n_vrd=%b cpu_ack=%b, want 0 0", n_vrd, cpu_ack);
    end
    tick();                                                // T+3
    checks++;
    if ({cpu_ack, cpu_rdata, n_vrd, va} !== {1'b1, 8'hA5, 1'b1, 19'h00005}) begin
      errors++;
      $display("FAIL rd_ack: got ack=%b rdata=%h n_vrd=%b va=%h, want 1 a5 1 00005", cpu_ack, cpu_rdata, n_vrd, va);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write();
    logic [7:0] rd;
    int lat;
    cpu_wr = 1'b1; cpu_addr = 19'h04000; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    tick();                                                // T+1
    checks++;
    if ({vd_oe, n_vwr, n_vrd, vd_o} !== {1'b1, 1'b0, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL wr_access1: got oe=%b n_vwr=%b n_vrd=%b vd_o=%h, want 1 0 1 3c", vd_oe, n_vwr, n_vrd, vd_o);
    end
    tick();                                                // T+2
    checks++;
    if ({vd_oe, n_vwr, vd_o} !== {1'b1, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL wr_hold: got oe=%b n_vwr=%b vd_o=%h, want 1 1 3c", vd_oe, n_vwr, vd_o);
    end
    tick();                                                // T+3
    checks++;
    if ({cpu_ack, vd_oe, cpu_rdata, mem[19'h04000]} !== {1'b1, 1'b0, 8'hA5, 8'h3C}) begin
      errors++;
      $display("FAIL wr_ack: got ack=%b oe=%b rdata=%h mem=%h, want 1 0 a5 3c", cpu_ack, vd_oe, cpu_rdata, mem[19'h04000]);
    end
    cpu_req = 1'b0;
    tick();
    cpu_xfer(1'b0, 19'h04000, 8'h00, rd, lat);
    checks++;
    if (rd !== 8'h3C || lat != 3) begin
      errors++;
      $display("FAIL wr_readback: got data=%h lat=%0d, want 3c 3", rd, lat);
    end
    tick();
  endtask

  task automatic test_vid_cpu_collision();
    int vt = 0, ct = 0;
    logic [7:0] vd = 8'h00, cd = 8'h00;
    vid_addr = 19'h01000; cpu_wr = 1'b0; cpu_addr = 19'h02000;
    vid_req = 1'b1; cpu_req = 1'b1;
    for (int i = 1; i <= 30 && ct == 0; i++) begin
      tick();
      if (vid_ack && cpu_ack) begin
        errors++;
        $display("FAIL ack_exclusive: vid_ack and cpu_ack both 1 at cycle %0d, want at most one", i);
      end
      if (vid_ack) begin vt = i; vd = vid_data; vid_req = 1'b0; end
      if (cpu_ack) begin ct = i; cd = cpu_rdata; cpu_req = 1'b0; end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    checks++;
    if (vt != 3 || vd !== 8'h99) begin
      errors++;
      $display("FAIL collide_vid: got ack cycle %0d data %h, want 3 99", vt, vd);
    end
    checks++;
    if (ct != 7 || cd !== 8'h42) begin
      errors++;
      $display("FAIL collide_cpu: got ack cycle %0d data %h, want 7 42", ct, cd);
    end
    tick();
  endtask

  task automatic test_starvation();
    int nvid = 0, ct = 0, rt = 0;
    vid_addr = 19'h01000; cpu_wr = 1'b0; cpu_addr = 19'h02000;
    vid_req = 1'b1; cpu_req = 1'b1;
    for (int i = 1; i <= 60 && rt == 0; i++) begin
      tick();
      if (vid_ack && ct == 0) nvid++;
      if (vid_ack && ct != 0) rt = i;
      if (cpu_ack) begin ct = i; cpu_req = 1'b0; end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    checks++;
    if (nvid != 4 || ct != 19) begin
      errors++;
      $display("FAIL starve_cpu: got %0d vid acks then cpu ack at %0d, want 4 and 19", nvid, ct);
    end
    checks++;
    if (rt != 23) begin
      errors++;
      $display("FAIL starve_resume: got video resume ack at %0d, want 23", rt);
    end
    tick();
  endtask

  task automatic test_dma();
    logic [7:0] rd;
    int lat, ct = 0, dt = 0;
    dma_xfer(1'b0, 19'h12345, 8'h00, rd, lat);
    checks++;
    if (rd !== 8'h5A || lat != 3) begin
      errors++;
      $display("FAIL dma_read: got data=%h lat=%0d, want 5a 3", rd, lat);
    end
    tick();
    dma_xfer(1'b1, 19'h12346, 8'hC3, rd, lat);
    checks++;
    if (mem[19'h12346] !== 8'hC3 || lat != 3 || dma_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL dma_write: got mem=%h lat=%0d rdata=%h, want c3 3 5a", mem[19'h12346], lat, dma_rdata);
    end
    tick();
    cpu_wr = 1'b0; cpu_addr = 19'h00005; dma_wr = 1'b0; dma_addr = 19'h12346;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 1; i <= 30 && dt == 0; i++) begin
      tick();
      if (cpu_ack) begin ct = i; cpu_req = 1'b0; end
      if (dma_ack) begin dt = i; dma_req = 1'b0; end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    checks++;
    if (ct != 3 || dt != 7 || dma_rdata !== 8'hC3 || cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL dma_vs_cpu: got cpu ack %0d dma ack %0d dma=%h cpu=%h, want 3 7 c3 a5",
               ct, dt, dma_rdata, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    int nvid = 0, ct = 0;
    // Reset during a write access
    cpu_wr = 1'b1; cpu_addr = 19'h00100; cpu_wdata = 8'h77; cpu_req = 1'b1;
    tick();
    checks++;
    if ({vd_oe, n_vwr} !== 2'b10) begin
      errors++;
      $display("FAIL rst_pre: got oe=%b n_vwr=%b, want 1 0", vd_oe, n_vwr);
    end
    rst_n = 1'b0; cpu_req = 1'b0;
    tick();
    checks++;
    if ({n_vwr, vd_oe, cpu_ack, va, cpu_rdata} !== {1'b1, 1'b0, 1'b0, 19'h0, 8'h00}) begin
      errors++;
      $display("FAIL rst_abort: got n_vwr=%b oe=%b ack=%b va=%h rdata=%h, want 1 0 0 0 0",
               n_vwr, vd_oe, cpu_ack, va, cpu_rdata);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({cpu_ack, vid_ack, dma_ack, n_vrd, n_vwr} !== 5'b00011) begin
      errors++;
      $display("FAIL rst_release: got acks=%b%b%b n_vrd=%b n_vwr=%b, want 000 1 1",
               cpu_ack, vid_ack, dma_ack, n_vrd, n_vwr);
    end
    // Build a streak of 3, reset, then expect a full 4 video grants before CPU
    vid_addr = 19'h01000; cpu_wr = 1'b0; cpu_addr = 19'h02000;
    vid_req = 1'b1; cpu_req = 1'b1;
    for (int i = 1; i <= 30 && nvid < 3; i++) begin
      tick();
      if (vid_ack) nvid++;
    end
    rst_n = 1'b0; vid_req = 1'b0; cpu_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    nvid = 0;
    vid_req = 1'b1; cpu_req = 1'b1;
    for (int i = 1; i <= 60 && ct == 0; i++) begin
      tick();
      if (vid_ack) nvid++;
      if (cpu_ack) begin ct = i; cpu_req = 1'b0; vid_req = 1'b0; end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    checks++;
    if (nvid != 4 || ct != 19) begin
      errors++;
      $display("FAIL rst_streak: got %0d vid acks then cpu ack at %0d, want 4 and 19", nvid, ct);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_wr = 1'b0; dma_wr = 1'b0;
    vid_addr = '0; cpu_addr = '0; dma_addr = '0;
    cpu_wdata = '0; dma_wdata = '0;
    mem[19'h00005] <= 8'hA5;
    mem[19'h01000] <= 8'h99;
    mem[19'h02000] <= 8'h42;
    mem[19'h12345] <= 8'h5A;
    mem[19'h00100] <= 8'h11;
    mem[19'h04000] <= 8'h00;
    mem[19'h12346] <= 8'h00;
    mem[19'h00000] <= 8'h00;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_cpu_read();
    test_cpu_write();
    test_vid_cpu_collision();
    test_starvation();
    test_dma();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zx_mem_arbiter.md
Name: zx_mem_arbiter

Overview:
- Shares the single external video/CPU SRAM bus (va/vd/n_vrd/n_vwr) among three requesters: video fetch, CPU and a DMA engine (SD/tape loader).
- Runs in the 28 MHz domain.
- Performs fixed-priority arbitration with a CPU anti-starvation counter, sequences each SRAM access and returns read data with a one-cycle ack.

Parameters:
RD_CYCLES, 2, clk28 cycles n_vrd is held low per read (min 1)
WR_CYCLES, 2, clk28 cycles per write; n_vwr is low for the first WR_CYCLES-1 of them (min 2)
CPU_STARVE_MAX, 4, consecutive video grants with CPU pending before CPU is forced ahead of video

Ports:
clk28  in  1  system clock, 28 MHz
rst_n  in  1  synchronous reset, active low
vid_req  in  1  video read request (level)
vid_addr  in  19  video address
vid_ack  out  1  one-cycle read-complete strobe
vid_data  out  8  video read data
cpu_req  in  1  CPU request (level)
cpu_wr  in  1  1=write, 0=read
cpu_addr  in  19  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion strobe
cpu_rdata  out  8  CPU read data
dma_req  in  1  DMA request (level)
dma_wr  in  1  1=write, 0=read
dma_addr  in  19  DMA address
dma_wdata  in  8  DMA write data
dma_ack  out  1  one-cycle completion strobe
dma_rdata  out  8  DMA read data
va  out  19  SRAM address
vd_i  in  8  SRAM data in
vd_o  out  8  SRAM write data
vd_oe  out  1  drive enable for vd_o
n_vrd  out  1  SRAM read strobe, active low
n_vwr  out  1  SRAM write strobe, active low

Behaviour:
- Reset (rst_n=0 at a clk28 edge): state IDLE; va=0, vd_o=0, vd_oe=0, n_vrd=1, n_vwr=1; all acks 0; all rdata/vid_data 0; streak counter 0. Reset mid-access aborts the access immediately and issues no ack.
- State machine IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - Requests are sampled here only.
  - Winner: CPU if cpu_req && streak==CPU_STARVE_MAX; else video, then CPU, then DMA.
  - On a grant, latch owner, addr, wr and wdata; load the access counter with RD_CYCLES-1 (read) or WR_CYCLES-1 (write); go to ACCESS.
  - Video is always a read.
  - With no request, stay in IDLE.
- ACCESS:
  - va = latched address throughout.
  - Read: n_vrd=0 for all RD_CYCLES cycles. vd_i is captured into the owner's data register on the last ACCESS cycle.
  - Write: vd_oe=1 and vd_o=wdata for all WR_CYCLES cycles. n_vwr=0 except in the last cycle (data hold).
  - When the counter reaches 0, go to ACK.
- ACK:
  - One cycle. The owner's ack=1; the new rdata is already valid and is held until the owner's next read completes.
  - n_vrd=n_vwr=1, vd_oe=0 (bus turnaround). va holds its value.
  - Requests are ignored in this cycle. Go to IDLE.
- Requester rule: req stays high until ack. req must be low in the cycle after ack unless a new request is made. Address and data must be stable while req is high.
- Latency: a request first seen in IDLE at cycle T gives ack at T+N+1, where N = RD_CYCLES or WR_CYCLES. Minimum back-to-back period is N+2 cycles.
- Streak counter (3+ bits, saturating at CPU_STARVE_MAX):
  - Increments on each video grant made while cpu_req=1.
  - Clears on a CPU grant.
  - Clears on any grant made while cpu_req=0.
- DMA has no starvation guarantee.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep req high and compete again at the next IDLE.
- At most one ack is high in any cycle. n_vrd and n_vwr are never low together. vd_oe=1 only during write ACCESS.

Test Plan:
1. Defaults; cpu_req read, addr=0x00005, SRAM[5]=0xA5, first sampled in IDLE at cycle T -> n_vrd low at T+1..T+2, va=0x00005, cpu_ack=1 at T+3 with cpu_rdata=0xA5.
2. cpu write addr=0x4000, data=0x3C -> vd_oe=1 for 2 cycles, n_vwr low 1 cycle; SRAM[0x4000]=0x3C; cpu_ack at T+3; read-back returns 0x3C.
3. vid_req and cpu_req both rise in the same IDLE cycle -> video granted first (vid_ack at T+3); CPU granted at the next IDLE (cpu_ack at T+7).
4. vid_req held high continuously, cpu_req pending, CPU_STARVE_MAX=4 -> exactly 4 vid_acks, then cpu_ack, then video resumes.
5. dma_req with vid/cpu idle -> dma read completes with dma_ack. With cpu_req also asserted -> CPU is served first and DMA next.
6. rst_n=0 during write ACCESS -> next cycle n_vwr=1, vd_oe=0, no ack; after release, state IDLE and streak=0.
